// File: rtl/mips_mc_controller_ext_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : mips_decls_p                                               |
// | Description : Shared declarations for the extended multicycle MIPS       |
// |               controller: opcode/funct encodings, controller states,     |
// |               ALU operation selector and ALU control codes.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mips_decls_p;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  // Opcodes (instr[31:26])
  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_J     = 6'b000010;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_BNE   = 6'b000101;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_SLTI  = 6'b001010;
  localparam opcode_t OP_ANDI  = 6'b001100;
  localparam opcode_t OP_ORI   = 6'b001101;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam funct_t F_ADD = 6'b100000;
  localparam funct_t F_SUB = 6'b100010;
  localparam funct_t F_AND = 6'b100100;
  localparam funct_t F_OR  = 6'b100101;
  localparam funct_t F_SLT = 6'b101010;

  // Controller states, explicit 4-bit encoding
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12,
    S_ILLEGAL = 4'd13
  } ctrl_state_t;

  // ALU operation selector from the main FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OPC   = 2'b11
  } aluop_t;

  // ALU control codes (3 significant bits)
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True for the R-type function codes the datapath can execute
  function automatic logic is_rtype_funct(input funct_t f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mc_controller_ext_aludec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aludec_ext                                                 |
// | Description : Combinational ALU decoder. Maps the FSM's aluop (plus      |
// |               funct for R-type, opcode for immediate logic ops) to the   |
// |               ALU control code.                                          |
// | Ports       : aluop_i      - operation selector from the main FSM        |
// |               opcode_i     - instruction opcode (used when aluop = 11)   |
// |               funct_i      - instruction funct  (used when aluop = 10)   |
// |               alucontrol_o - ALU code, upper bits above bit 2 are 0      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aludec_ext
  import mips_decls_p::*;
#(
  parameter int ALUCTL_W = 3   // must be >= 3
) (
  input  aluop_t                aluop_i,
  input  opcode_t               opcode_i,
  input  funct_t                funct_i,
  output logic [ALUCTL_W-1:0]   alucontrol_o
);

  logic [2:0] w_code;

  always_comb begin
    w_code = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_ADD:   w_code = ALU_ADD;
          F_SUB:   w_code = ALU_SUB;
          F_AND:   w_code = ALU_AND;
          F_OR:    w_code = ALU_OR;
          F_SLT:   w_code = ALU_SLT;
          // Unreachable in practice: unknown functs divert to ILLEGAL
          default: w_code = ALU_ADD;
        endcase
      end
      ALUOP_OPC: begin
        case (opcode_i)
          OP_ANDI: w_code = ALU_AND;
          OP_ORI:  w_code = ALU_OR;
          OP_SLTI: w_code = ALU_SLT;
          default: w_code = ALU_ADD;
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  // Zero-extend to the configured width
  assign alucontrol_o = ALUCTL_W'(w_code);

endmodule
`default_nettype wire

// File: rtl/mips_mc_controller_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mips_mc_controller_ext                                     |
// | Description : Multicycle MIPS control unit. Moore main FSM with memory   |
// |               ready handshake, illegal-instruction detection, BNE and    |
// |               ANDI/ORI/SLTI support, plus the ALU decoder.               |
// | Ports       : clk, reset (async, active-low)                             |
// |               opcode, funct, zero, memready - instruction / status in    |
// |               pcen, memread, memwrite, irwrite, regwrite - enables out   |
// |               alusrca, iord, memtoreg, regdst, zeroext, alusrcb, pcsrc - |
// |               datapath mux selects; alucontrol - ALU code;               |
// |               illegal - one-cycle pulse on an undecodable instruction    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mips_mc_controller_ext
  import mips_decls_p::*;
#(
  parameter int ALUCTL_W    = 3,
  parameter int EN_BNE      = 1,
  parameter int EN_IMMLOGIC = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  opcode_t             opcode,
  input  funct_t              funct,
  input  logic                zero,
  input  logic                memready,
  output logic                pcen,
  output logic                memread,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regwrite,
  output logic                alusrca,
  output logic                iord,
  output logic                memtoreg,
  output logic                regdst,
  output logic                zeroext,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal
);

  ctrl_state_t state_q, state_d;

  logic   w_memread, w_memwrite, w_irwrite, w_regwrite, w_illegal;
  logic   w_pcwrite, w_branch, w_branchne;
  aluop_t w_aluop;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = is_rtype_funct(funct) ? S_RTYPEEX : S_ILLEGAL;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = (EN_BNE != 0) ? S_BNEEX : S_ILLEGAL;
          OP_ADDI:      state_d = S_IMMEX;
          OP_ANDI, OP_ORI, OP_SLTI:
                        state_d = (EN_IMMLOGIC != 0) ? S_IMMEX : S_ILLEGAL;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      // Only LW/SW reach MEMADR, so anything but SW is a load
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (memready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (memready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_BNEEX:   state_d = S_FETCH;
      S_IMMEX:   state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      S_ILLEGAL: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // ------------------------------------------------------- state outputs
  always_comb begin
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_branchne = 1'b0;
    w_aluop    = ALUOP_ADD;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    zeroext    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        w_memread = 1'b1;
        alusrcb   = 2'b01;
        // IR load and PC+4 commit only when the fetch actually completes
        w_irwrite = memready;
        w_pcwrite = memready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        w_memread = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_BNEEX: begin
        alusrca    = 1'b1;
        w_aluop    = ALUOP_SUB;
        pcsrc      = 2'b01;
        w_branchne = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zeroext = (opcode == OP_ANDI) || (opcode == OP_ORI);
        w_aluop = (opcode == OP_ADDI) ? ALUOP_ADD : ALUOP_OPC;
      end
      S_IMMWB:   w_regwrite = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_ILLEGAL: w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Write enables and requests are gated by reset so that an asynchronous
  // reset kills them immediately, even though FETCH itself requests a read.
  assign memread  = reset & w_memread;
  assign memwrite = reset & w_memwrite;
  assign irwrite  = reset & w_irwrite;
  assign regwrite = reset & w_regwrite;
  assign illegal  = reset & w_illegal;
  assign pcen     = reset & (w_pcwrite | (w_branch & zero) | (w_branchne & ~zero));

  // ---------------------------------------------------------- ALU decoder
  aludec_ext #(
    .ALUCTL_W (ALUCTL_W)
  ) u_aludec (
    .aluop_i      (w_aluop),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mips_mc_controller_ext                                  |
// | Description : Self-checking bench. Instance A uses default parameters,   |
// |               instance B disables BNE/immediate-logic and widens the ALU |
// |               code. An instruction-level model expands each instruction  |
// |               into its expected per-cycle outputs.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mips_mc_controller_ext;

  localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_BEQ = 6'h04, T_BNE = 6'h05,
                         T_ADDI = 6'h08, T_SLTI = 6'h0A, T_ANDI = 6'h0C,
                         T_ORI = 6'h0D, T_LW = 6'h23, T_SW = 6'h2B;
  localparam logic [5:0] T_FADD = 6'h20, T_FSUB = 6'h22, T_FAND = 6'h24,
                         T_FOR = 6'h25, T_FSLT = 6'h2A;

  localparam int K_PLAIN = 0, K_FETCH = 1, K_WAIT = 2, K_BEQ = 3, K_BNE = 4;

  typedef struct packed {
    logic pcen, memread, memwrite, irwrite, regwrite, alusrca, iord,
          memtoreg, regdst, zeroext, illegal;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alu;
  } outs_t;

  typedef struct {
    outs_t o;
    int    kind;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, memready = 1'b0;

  logic pcen_a, memread_a, memwrite_a, irwrite_a, regwrite_a, alusrca_a, iord_a,
        memtoreg_a, regdst_a, zeroext_a, illegal_a;
  logic [1:0] alusrcb_a, pcsrc_a;
  logic [2:0] alu_a;
  logic pcen_b, memread_b, memwrite_b, irwrite_b, regwrite_b, alusrca_b, iord_b,
        memtoreg_b, regdst_b, zeroext_b, illegal_b;
  logic [1:0] alusrcb_b, pcsrc_b;
  logic [3:0] alu_b;

  outs_t gotA, gotB, exp_o;
  assign gotA = {pcen_a, memread_a, memwrite_a, irwrite_a, regwrite_a, alusrca_a,
                 iord_a, memtoreg_a, regdst_a, zeroext_a, illegal_a, alusrcb_a,
                 pcsrc_a, 1'b0, alu_a};
  assign gotB = {pcen_b, memread_b, memwrite_b, irwrite_b, regwrite_b, alusrca_b,
                 iord_b, memtoreg_b, regdst_b, zeroext_b, illegal_b, alusrcb_b,
                 pcsrc_b, alu_b};

  int    checks = 0, failures = 0;
  bit    chk_en = 1'b0, sel = 1'b0;
  string tag = "reset";
  step_t steps[$];
  outs_t hist[$];

  mips_mc_controller_ext #(.ALUCTL_W(3), .EN_BNE(1), .EN_IMMLOGIC(1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .memready(memready), .pcen(pcen_a), .memread(memread_a), .memwrite(memwrite_a),
    .irwrite(irwrite_a), .regwrite(regwrite_a), .alusrca(alusrca_a), .iord(iord_a),
    .memtoreg(memtoreg_a), .regdst(regdst_a), .zeroext(zeroext_a),
    .alusrcb(alusrcb_a), .pcsrc(pcsrc_a), .alucontrol(alu_a), .illegal(illegal_a));

  mips_mc_controller_ext #(.ALUCTL_W(4), .EN_BNE(0), .EN_IMMLOGIC(0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .memready(memready), .pcen(pcen_b), .memread(memread_b), .memwrite(memwrite_b),
    .irwrite(irwrite_b), .regwrite(regwrite_b), .alusrca(alusrca_b), .iord(iord_b),
    .memtoreg(memtoreg_b), .regdst(regdst_b), .zeroext(zeroext_b),
    .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .alucontrol(alu_b), .illegal(illegal_b));

  always #5 clk = ~clk;

  // Single compare point, mid-cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      hist.push_back(sel ? gotB : gotA);
      checks++;
      if ((sel ? gotB : gotA) !== exp_o) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", tag, hist.size(),
                 sel ? gotB : gotA, exp_o);
      end
    end
  end

  // ------------------------------------------------------------- model
  function automatic outs_t idle_o();
    outs_t o;
    o = '0;
    o.alu = 4'b0010;
    return o;
  endfunction

  function automatic outs_t rst_o();
    outs_t o;
    o = idle_o();
    o.alusrcb = 2'b01;
    return o;
  endfunction

  function automatic bit r_legal(input logic [5:0] f);
    return f == T_FADD || f == T_FSUB || f == T_FAND || f == T_FOR || f == T_FSLT;
  endfunction

  function automatic logic [3:0] alu_of_funct(input logic [5:0] f);
    case (f)
      T_FSUB:  return 4'b0110;
      T_FAND:  return 4'b0000;
      T_FOR:   return 4'b0001;
      T_FSLT:  return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic push(input outs_t o, input int k);
    step_t s;
    s.o = o;
    s.kind = k;
    steps.push_back(s);
  endtask

  // Expand one instruction into the sequence of controller cycles it takes
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input bit en_bne, input bit en_imm);
    outs_t o;
    bit    imm_logic;
    steps.delete();
    o = idle_o(); o.memread = 1'b1; o.alusrcb = 2'b01; push(o, K_FETCH);
    o = idle_o(); o.alusrcb = 2'b11; push(o, K_PLAIN);
    imm_logic = (op == T_ANDI) || (op == T_ORI) || (op == T_SLTI);
    if (op == T_LW || op == T_SW) begin
      o = idle_o(); o.alusrca = 1'b1; o.alusrcb = 2'b10; push(o, K_PLAIN);
      o = idle_o(); o.iord = 1'b1;
      if (op == T_LW) begin
        o.memread = 1'b1; push(o, K_WAIT);
        o = idle_o(); o.regwrite = 1'b1; o.memtoreg = 1'b1; push(o, K_PLAIN);
      end else begin
        o.memwrite = 1'b1; push(o, K_WAIT);
      end
    end else if (op == T_R && r_legal(fn)) begin
      o = idle_o(); o.alusrca = 1'b1; o.alu = alu_of_funct(fn); push(o, K_PLAIN);
      o = idle_o(); o.regwrite = 1'b1; o.regdst = 1'b1; push(o, K_PLAIN);
    end else if (op == T_BEQ || (op == T_BNE && en_bne)) begin
      o = idle_o(); o.alusrca = 1'b1; o.pcsrc = 2'b01; o.alu = 4'b0110;
      push(o, (op == T_BEQ) ? K_BEQ : K_BNE);
    end else if (op == T_ADDI || (imm_logic && en_imm)) begin
      o = idle_o(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
      o.zeroext = (op == T_ANDI) || (op == T_ORI);
      o.alu = (op == T_ANDI) ? 4'b0000 : (op == T_ORI) ? 4'b0001 :
              (op == T_SLTI) ? 4'b0111 : 4'b0010;
      push(o, K_PLAIN);
      o = idle_o(); o.regwrite = 1'b1; push(o, K_PLAIN);
    end else if (op == T_J) begin
      o = idle_o(); o.pcsrc = 2'b10; o.pcen = 1'b1; push(o, K_PLAIN);
    end else begin
      o = idle_o(); o.illegal = 1'b1; push(o, K_PLAIN);
    end
  endtask

  // waits: memready-low cycles per memory-wait step (-1 = random, fetch too)
  // zmode: -1 = random zero flag, else fixed value
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input int waits, input int zmode,
                           input bit en_bne, input bit en_imm);
    int n;
    bit held;
    build(op, fn, en_bne, en_imm);
    hist.delete();
    tag = name;
    opcode = op;
    funct = fn;
    foreach (steps[i]) begin
      held = (steps[i].kind == K_FETCH) || (steps[i].kind == K_WAIT);
      if (!held)                     n = 0;
      else if (waits < 0)            n = $urandom_range(2, 0);
      else if (steps[i].kind == K_WAIT) n = waits;
      else                           n = 0;
      for (int k = 0; k <= n; k++) begin
        memready = held ? (k == n) : 1'($urandom_range(1, 0));
        zero = (zmode < 0) ? 1'($urandom_range(1, 0)) : zmode[0];
        exp_o = steps[i].o;
        if (steps[i].kind == K_FETCH) begin
          exp_o.irwrite = memready;
          exp_o.pcen = memready;
        end
        if (steps[i].kind == K_BEQ) exp_o.pcen = zero;
        if (steps[i].kind == K_BNE) exp_o.pcen = ~zero;
        chk_en = 1'b1;
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic outs_t hv(input int i);
    if (i < hist.size()) return hist[i];
    return '0;
  endfunction

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, want);
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(10, 0))
      0: return T_R;    1: return T_J;    2: return T_BEQ;  3: return T_BNE;
      4: return T_ADDI; 5: return T_SLTI; 6: return T_ANDI; 7: return T_ORI;
      8: return T_LW;   9: return T_SW;
      default: return 6'($urandom_range(63, 0));
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(5, 0))
      0: return T_FADD; 1: return T_FSUB; 2: return T_FAND;
      3: return T_FOR;  4: return T_FSLT;
      default: return 6'($urandom_range(63, 0));
    endcase
  endfunction

  // -------------------------------------------------------------- stimulus
  initial begin
    int cnt;
    // Reset held: FETCH mux values, all enables forced low even with memready
    @(posedge clk); #1;
    memready = 1'b1;
    opcode = T_LW;
    exp_o = rst_o();
    chk_en = 1'b1;
    @(posedge clk); #1;
    pin("rst_memread", memread_a, 0);
    pin("rst_irwrite", irwrite_a, 0);
    pin("rst_alusrcb", alusrcb_a, 1);
    reset = 1'b1;

    run_instr("lw", T_LW, 6'h00, 0, -1, 1, 1);
    pin("lw_len", hist.size(), 5);
    pin("lw_c5_regwrite", hv(4).regwrite, 1);
    pin("lw_c5_memtoreg", hv(4).memtoreg, 1);
    pin("lw_c4_regwrite", hv(3).regwrite, 0);

    run_instr("sw_wait", T_SW, 6'h00, 3, -1, 1, 1);
    cnt = 0;
    foreach (hist[i]) if (hist[i].memwrite && hist[i].iord) cnt++;
    pin("sw_memwrite_cycles", cnt, 4);
    pin("sw_len", hist.size(), 7);

    run_instr("beq_z1", T_BEQ, 6'h00, 0, 1, 1, 1);
    pin("beq_z1_pcen", hv(2).pcen, 1);
    pin("beq_z1_pcsrc", hv(2).pcsrc, 1);
    run_instr("bne_z1", T_BNE, 6'h00, 0, 1, 1, 1);
    pin("bne_z1_pcen", hv(2).pcen, 0);
    run_instr("bne_z0", T_BNE, 6'h00, 0, 0, 1, 1);
    pin("bne_z0_pcen", hv(2).pcen, 1);

    run_instr("ori", T_ORI, 6'h00, 0, -1, 1, 1);
    pin("ori_zeroext", hv(2).zeroext, 1);
    pin("ori_alu", hv(2).alu, 1);
    pin("ori_wb_regwrite", hv(3).regwrite, 1);
    pin("ori_wb_regdst", hv(3).regdst, 0);
    run_instr("addi", T_ADDI, 6'h00, 0, -1, 1, 1);
    pin("addi_zeroext", hv(2).zeroext, 0);
    pin("addi_alu", hv(2).alu, 2);

    run_instr("ill_op", 6'h3F, 6'h20, 0, -1, 1, 1);
    pin("ill_op_len", hist.size(), 3);
    pin("ill_op_pulse", hv(2).illegal, 1);
    run_instr("ill_fn", T_R, 6'h00, 0, -1, 1, 1);
    pin("ill_fn_pulse", hv(2).illegal, 1);
    pin("ill_fn_c2", hv(1).illegal, 0);

    // Asynchronous reset in the middle of a stalled store
    tag = "sw_rst";
    chk_en = 1'b0;
    opcode = T_SW;
    memready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    memready = 1'b0;
    #1;
    pin("sw_rst_before", memwrite_a, 1);
    reset = 1'b0;
    #1;
    pin("sw_rst_async_memwrite", memwrite_a, 0);
    exp_o = rst_o();
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #0;
    pin("sw_rst_release_memread", memread_a, 1);
    run_instr("after_rst", T_LW, 6'h00, 0, -1, 1, 1);

    for (int i = 0; i < 200; i++)
      run_instr("rand_a", pick_op(), pick_fn(), -1, -1, 1, 1);

    // Instance B: BNE and immediate logic ops are illegal, 4-bit ALU code
    reset = 1'b0;
    sel = 1'b1;
    tag = "rst_b";
    exp_o = rst_o();
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr("b_bne", T_BNE, 6'h00, 0, 0, 0, 0);
    pin("b_bne_len", hist.size(), 3);
    pin("b_bne_illegal", hv(2).illegal, 1);
    pin("b_bne_pcen", hv(2).pcen, 0);
    run_instr("b_andi", T_ANDI, 6'h00, 0, -1, 0, 0);
    pin("b_andi_illegal", hv(2).illegal, 1);
    for (int i = 0; i < 80; i++)
      run_instr("rand_b", pick_op(), pick_fn(), -1, -1, 0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
